// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - multi-cycle data-memory controller with programmable wait states
// Services one load/store at a time from a word-addressed RAM; flags misaligned, out-of-range and conflicting requests.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] wr_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic                  write_q;
  logic                  oor_q;
  logic                  conflict_q;
  logic [31:0]           mem [2**ADDR_WIDTH];

  logic req;
  logic misaligned;
  logic out_of_range;
  logic commit;

  assign req          = mem_read | mem_write;
  assign misaligned   = data_addr[1:0] != 2'b00;
  assign out_of_range = (data_addr >> (ADDR_WIDTH + 2)) != 32'd0;
  assign commit       = (state == ACCESS) && (wait_cnt == 4'd0);

  // A misaligned request is refused on the spot, so it never freezes the core.
  assign stall = (state == ACCESS) || ((state == IDLE) && req && !misaligned);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      addr_q     <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
      oor_q      <= 1'b0;
      conflict_q <= 1'b0;
      rd_data    <= '0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (misaligned) begin
              err <= 1'b1;
            end else begin
              addr_q     <= data_addr[ADDR_WIDTH+1:2];
              data_q     <= wr_data;
              write_q    <= mem_write;
              oor_q      <= out_of_range;
              conflict_q <= mem_read & mem_write;
              wait_cnt   <= WAIT_INIT;
              state      <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            if (!write_q) rd_data <= oor_q ? 32'd0 : mem[addr_q];
            err   <= oor_q | conflict_q;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Reset on the commit edge discards the in-flight store; RAM itself is never cleared.
  always_ff @(posedge clk) begin
    if (!rst && commit && write_q && !oor_q) mem[addr_q] <= data_q;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - scoreboard bench for data_mem_ctrl
// Stimulus pushes expected completions; a negedge monitor pops them when stall falls.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_addr = '0, wr_data = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] rd_data;
  logic        stall, err;

  logic [31:0] addr0 = '0, wdata0 = '0;
  logic        read0 = 1'b0, write0 = 1'b0;
  logic [31:0] rd0;
  logic        stall0, err0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .data_addr(data_addr), .wr_data(wr_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .rd_data(rd_data), .stall(stall), .err(err)
  );

  data_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .data_addr(addr0), .wr_data(wdata0),
    .mem_read(read0), .mem_write(write0),
    .rd_data(rd0), .stall(stall0), .err(err0)
  );

  typedef struct {
    logic [31:0] rd;
    logic [31:0] err;
    logic [31:0] len;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: a falling stall marks the DONE cycle of a completed access.
  int scnt = 0;
  bit aborted = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      scnt = 0;
      aborted = 1'b1;
    end else if (stall) begin
      scnt++;
    end else begin
      if (scnt > 0 && !aborted) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got completion expected none at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("done_rd_data", rd_data, e.rd);
          check("done_err", 32'(err), e.err);
          check("stall_len", 32'(scnt), e.len);
        end
      end
      scnt = 0;
      aborted = 1'b0;
    end
  end

  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w,
                        input logic [31:0] exp_rd, input logic exp_err, input int drop_after);
    exp_t e;
    int n;
    e.rd = exp_rd;
    e.err = 32'(exp_err);
    e.len = 32'd4;
    sb.push_back(e);
    data_addr = a;
    wr_data = d;
    mem_read = r;
    mem_write = w;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n == drop_after) begin
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
      end
      if (n > 40) begin
        checks++;
        failures++;
        $display("FAIL access_timeout: got stall stuck expected release addr 0x%08h", a);
        break;
      end
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic access0(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [31:0] exp_rd);
    int n;
    n = 0;
    addr0 = a;
    wdata0 = d;
    read0 = !w;
    write0 = w;
    forever begin
      @(negedge clk);
      if (!stall0) break;
      n++;
      if (n > 40) break;
    end
    check("ws0_stall_len", 32'(n), 32'd2);
    check("ws0_rd_data", rd0, exp_rd);
    check("ws0_err", 32'(err0), 32'd0);
    @(posedge clk);
    #1;
    read0 = 1'b0;
    write0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_rd0", rd0, 32'd0);
    @(posedge clk);
    #1;

    access(32'h14, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, 1'b0, 0);
    access(32'h14, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 0);
    access(32'h20, 32'h12345678, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 0);
    access(32'h20, 32'h0, 1'b1, 1'b0, 32'h12345678, 1'b0, 0);

    // Misaligned store to 0x22: refused without stall, err pulses once.
    data_addr = 32'h22;
    wr_data = 32'hFFFFFFFF;
    mem_write = 1'b1;
    @(negedge clk);
    check("misalign_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1 mem_write = 1'b0;
    @(negedge clk);
    check("misalign_err", 32'(err), 32'd1);
    check("misalign_rd_held", rd_data, 32'h12345678);
    @(negedge clk);
    check("misalign_err_clear", 32'(err), 32'd0);
    check("misalign_idle_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    access(32'h20, 32'h0, 1'b1, 1'b0, 32'h12345678, 1'b0, 0);

    // Out of range: 0x1000 would alias word 0 if not dropped.
    access(32'h0, 32'h0000CAFE, 1'b0, 1'b1, 32'h12345678, 1'b0, 0);
    access(32'h1000, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 0);
    access(32'h1000, 32'h99999999, 1'b0, 1'b1, 32'h0, 1'b1, 0);
    access(32'h0, 32'h0, 1'b1, 1'b0, 32'h0000CAFE, 1'b0, 0);
    access(32'h20, 32'h0, 1'b1, 1'b0, 32'h12345678, 1'b0, 0);

    // Read and write together behave as a write with err.
    access(32'h24, 32'h55AA55AA, 1'b1, 1'b1, 32'h12345678, 1'b1, 0);
    access(32'h24, 32'h0, 1'b1, 1'b0, 32'h55AA55AA, 1'b0, 0);

    // Request dropped during ACCESS still completes.
    access(32'h14, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 2);

    // Reset in the second ACCESS cycle of a store discards it.
    access(32'h08, 32'h0BADF00D, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 0);
    data_addr = 32'h08;
    wr_data = 32'hAAAA5555;
    mem_write = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check("rstmid_stall", 32'(stall), 32'd0);
    check("rstmid_rd_data", rd_data, 32'd0);
    check("rstmid_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    access(32'h08, 32'h0, 1'b1, 1'b0, 32'h0BADF00D, 1'b0, 0);

    access0(32'h4, 32'h00000077, 1'b1, 32'h0);
    access0(32'h4, 32'h0, 1'b0, 32'h00000077);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Multi-cycle data-memory controller that sits directly downstream of the CPU's data port (`data_addr`, `data_out`, `mem_read`, `mem_write`, `data_in`). It owns a word-addressed on-chip RAM and services one load or store at a time with a programmable number of wait states. It returns load data to the CPU's `data_in` and raises `stall` to freeze the core while an access is in flight. It also flags misaligned and out-of-range accesses on `err`.

## Interface
- `ADDR_WIDTH`, 10: log2 of RAM depth in 32-bit words; byte addresses `[ADDR_WIDTH+1:2]` index the array.
- `WAIT_STATES`, 2: extra ACCESS cycles before completion; legal range 0..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `data_addr` input 32: byte address from the CPU.
- `wr_data` input 32: store data; connects to the CPU's `data_out`.
- `mem_read` input 1: load request, level-held by the CPU until `stall` drops.
- `mem_write` input 1: store request, level-held by the CPU until `stall` drops.
- `rd_data` output 32: load result, registered; connects to the CPU's `data_in`.
- `stall` output 1: freeze the CPU; combinational from state and request.
- `err` output 1: registered one-cycle pulse for a misaligned, out-of-range, or conflicting request.

## Operation
- FSM states: IDLE, ACCESS, DONE. Wait counter is 4 bits wide.
- **IDLE, no request:** `stall`=0 and the FSM holds.
- **IDLE, request present** (`mem_read|mem_write`):
  - `stall`=1.
  - At the clock edge, latch the word address, `wr_data`, and the op.
  - Load counter with `WAIT_STATES` and go to ACCESS.
- **Both `mem_read` and `mem_write` high:** treat the request as a write; pulse `err`.
- **Misaligned request** (`data_addr[1:0]`≠0):
  - No access, no stall: `stall`=0 in that same cycle.
  - Pulse `err` next cycle; stay in IDLE.
  - `rd_data` is unchanged.
- **Out-of-range request** (any of `data_addr[31:ADDR_WIDTH+2]`≠0):
  - The normal FSM sequence runs with full stall timing.
  - A read returns 0; a write is dropped.
  - Pulse `err` in the DONE cycle.
- **ACCESS:** `stall`=1.
  - If counter≠0, decrement it.
  - If counter==0: a read loads `rd_data` ← RAM[latched addr]; a write stores RAM[latched addr] ← latched data; go to DONE.
- **DONE:** `stall`=0 and `rd_data` is valid. The CPU commits the instruction this cycle; go to IDLE unconditionally.
  - A request still asserted in DONE belongs to the completed access and is not re-issued.
- **Request withdrawn mid-access:** the latched access still completes, including the write commit.
- **Reset:**
  - On assertion: FSM → IDLE, `stall`=0, `rd_data`=0, `err`=0.
  - An in-flight write is discarded if reset arrives before the ACCESS completion edge.
  - RAM contents are not cleared.
- `rd_data` holds its last value across writes and idle cycles. It changes only on a read completion or on reset.

## Timing
- Request first visible in cycle N (IDLE):
  - `stall` is high in cycles N..N+WAIT_STATES+1.
  - DONE is cycle N+WAIT_STATES+2, with `stall` low.
- Stall length is therefore WAIT_STATES+2 cycles; with WAIT_STATES=0 it is 2 cycles.
- Write commit edge is the end of cycle N+WAIT_STATES+1. A read issued in the cycle after DONE sees the new data.
- Back-to-back accesses: the earliest next request is accepted in the IDLE cycle immediately after DONE. Minimum period is WAIT_STATES+3 cycles per access.
- `err` for a misaligned request: high in cycle N+1 only.
- `err` for an out-of-range or conflicting request: high in the DONE cycle only.
- `stall` is combinational. It depends on the FSM state, `mem_read`, `mem_write`, and `data_addr[1:0]`; it has no path from `wr_data`.

## Test plan
- **Reset then load:** preload RAM[5]=0xDEADBEEF; with WAIT_STATES=2, hold `mem_read`, `data_addr`=0x14 from cycle N → `stall` high N..N+3, DONE at N+4 with `rd_data`=0xDEADBEEF, `err`=0.
- **Store/load back-to-back:** write 0x12345678 to 0x20, then read 0x20 in the cycle after DONE → `rd_data`=0x12345678; each access stalls 4 cycles; no `err`.
- **Misaligned:** `mem_write`, `data_addr`=0x22 → `stall` stays 0; `err` is 1 for exactly one cycle; RAM[8] unchanged; FSM stays in IDLE.
- **Out of range:** with ADDR_WIDTH=10, read `data_addr`=0x1000 → full 4-cycle stall, `rd_data`=0, `err` pulses in DONE. Then a write to the same address leaves the whole RAM unchanged.
- **Reset mid-write:** assert `rst` during the second ACCESS cycle of a write of 0xAAAA5555 to 0x08 → next cycle `stall`=0, `rd_data`=0; a subsequent read of 0x08 returns the prior value.
- **Corner cases:**
  - `mem_read` and `mem_write` high together → treated as a write, with `err` in DONE.
  - WAIT_STATES=0 → stall of 2 cycles.
  - `mem_read` dropped during ACCESS → the access still completes through DONE and returns to IDLE.
